// File: rtl/audio_meter_pkg.sv
// Shared types and defaults for the audio-block tone meters.
package audio_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } meter_state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 131071;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous square wave and flags every toggle (either direction).
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tone_in,
  output logic tone_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q[0] <= tone_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      s_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tone_edge = sync_q[SYNC_STAGES-1] ^ s_prev;

endmodule

// File: rtl/frequency_meter.sv
// Half-period meter: counts clock cycles between tone toggles and reports the
// result on a valid/ready port, with lock and loss-of-signal status.
//
//   state   | meaning
//   IDLE    | after reset; waiting for the first toggle to arm the count
//   MEASURE | counting cycles since the last toggle
//   LOST    | no toggle for TIMEOUT_CYCLES; next toggle re-arms, no result
module frequency_meter
  import audio_meter_pkg::*;
#(
  parameter int          WIDTH          = 17,
  parameter int          SYNC_STAGES    = 2,
  parameter int          LOCK_COUNT     = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tone_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             locked,
  output logic             no_signal
);

  localparam int                 MATCH_W   = $clog2(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WIDTH-1:0]   TIMEOUT   = WIDTH'(TIMEOUT_CYCLES);

  meter_state_t       state, state_nxt;
  logic [WIDTH-1:0]   cnt, cnt_nxt;
  logic [MATCH_W-1:0] match, match_inc;
  logic               tone_edge;
  logic               new_result, lost_now, found_now;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clock     (clock),
    .reset_n   (reset_n),
    .tone_in   (tone_in),
    .tone_edge (tone_edge)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    new_result = 1'b0;
    lost_now   = 1'b0;
    found_now  = 1'b0;
    case (state)
      IDLE: begin
        if (tone_edge) begin
          cnt_nxt   = WIDTH'(1);
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (tone_edge) begin
          new_result = 1'b1;
          cnt_nxt    = WIDTH'(1);
        end else if (cnt == TIMEOUT) begin
          lost_now  = 1'b1;
          state_nxt = LOST;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end
      LOST: begin
        if (tone_edge) begin
          found_now = 1'b1;
          cnt_nxt   = WIDTH'(1);
          state_nxt = MEASURE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating match counter; period always holds the previous result.
  assign match_inc = (match == MATCH_MAX) ? MATCH_MAX : match + MATCH_W'(1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      match        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      locked       <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;

      if (lost_now) begin
        no_signal <= 1'b1;
        locked    <= 1'b0;
        match     <= '0;
      end else if (found_now) begin
        no_signal <= 1'b0;
      end

      if (new_result) begin
        period       <= cnt;
        period_valid <= 1'b1;
        if (cnt == period) begin
          match  <= match_inc;
          locked <= (match_inc == MATCH_MAX);
        end else begin
          match  <= '0;
          locked <= 1'b0;
        end
      end else if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end

      if (new_result && period_valid && !period_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter with a timestamp-based reference model.
module tb_frequency_meter;

  localparam int W = 17;
  localparam int S = 2;
  localparam int L = 4;
  localparam int T = 100;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         tone_in = 1'b0;
  logic         period_ready = 1'b0;
  logic         overrun_clr = 1'b0;
  logic [W-1:0] period;
  logic         period_valid;
  logic         overrun;
  logic         locked;
  logic         no_signal;

  always #5 clock = ~clock;

  frequency_meter #(
    .WIDTH(W), .SYNC_STAGES(S), .LOCK_COUNT(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tone_in      (tone_in),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .locked       (locked),
    .no_signal    (no_signal)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, k);
    end
  endtask

  // Reference model: toggles are timestamped by the posedge that first samples
  // them; the meter sees a toggle S cycles later and reports the timestamp gap.
  bit           zq[$] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int           last_edge = 0;
  bit           armed = 1'b0;
  int           res_q[$];
  int           since = 0;
  logic [W-1:0] m_period = '0;
  bit           m_valid = 1'b0, m_overrun = 1'b0, m_locked = 1'b0, m_nosig = 1'b0;

  always @(posedge clock) begin : model_b
    bit e, fire, all_eq;
    int res;
    k++;
    zq.push_back(reset_n ? tone_in : 1'b0);
    void'(zq.pop_front());
    e = (zq[1] != zq[0]);
    fire = 1'b0;
    res = 0;
    if (!reset_n) begin
      armed = 1'b0; since = 0; res_q.delete();
      m_period = '0; m_valid = 1'b0; m_overrun = 1'b0; m_locked = 1'b0; m_nosig = 1'b0;
    end else begin
      if (e) begin
        if (armed) begin
          fire = 1'b1;
          res = k - last_edge;
        end
        armed = 1'b1;
        last_edge = k;
        m_nosig = 1'b0;
      end else if (armed && (k - last_edge == T)) begin
        armed = 1'b0;
        m_nosig = 1'b1;
        m_locked = 1'b0;
        since = 0;
      end
      if (fire) begin
        if (m_valid && !period_ready) m_overrun = 1'b1;
        else if (overrun_clr) m_overrun = 1'b0;
        m_period = W'(res);
        m_valid = 1'b1;
        res_q.push_back(res);
        if (res_q.size() > L) void'(res_q.pop_front());
        since++;
        // Locked when the last L results agree and L-1 of them came after any loss.
        all_eq = (res_q.size() >= L) && (since >= L - 1);
        for (int i = 1; i < L; i++)
          if (all_eq && res_q[res_q.size()-1-i] != res) all_eq = 1'b0;
        m_locked = all_eq;
      end else begin
        if (m_valid && period_ready) m_valid = 1'b0;
        if (overrun_clr) m_overrun = 1'b0;
      end
    end
  end

  always @(negedge clock) begin : compare_b
    check("period", int'(period), int'(m_period));
    check("period_valid", int'(period_valid), int'(m_valid));
    check("overrun", int'(overrun), int'(m_overrun));
    check("locked", int'(locked), int'(m_locked));
    check("no_signal", int'(no_signal), int'(m_nosig));
  end

  task automatic tog(input int p);
    tone_in = ~tone_in;
    repeat (p) @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_valid"}, int'(period_valid), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_nosig"}, int'(no_signal), 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    period_ready = 1'b1;

    // Steady period 5 locks after four identical results.
    repeat (6) tog(5);
    check("p5_period", int'(period), 5);
    check("p5_locked", int'(locked), 1);

    // Switch to 9: first 9 breaks lock, four 9s relock.
    tog(9);
    tog(9);
    check("p9_first_period", int'(period), 9);
    check("p9_first_locked", int'(locked), 0);
    repeat (3) tog(9);
    check("p9_relock", int'(locked), 1);

    // Toggle every cycle.
    repeat (10) tog(1);
    repeat (4) @(negedge clock);
    check("p1_period", int'(period), 1);
    check("p1_overrun", int'(overrun), 0);
    check("p1_locked", int'(locked), 1);

    // Back-pressure with period 7.
    period_ready = 1'b0;
    repeat (4) tog(7);
    check("p7_period", int'(period), 7);
    check("p7_valid", int'(period_valid), 1);
    check("p7_overrun", int'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    check("ovr_clr", int'(overrun), 0);
    period_ready = 1'b1;
    @(negedge clock);
    check("accept_drop", int'(period_valid), 0);

    // Loss of signal and recovery.
    repeat (T + 10) @(negedge clock);
    check("lost_nosig", int'(no_signal), 1);
    check("lost_locked", int'(locked), 0);
    tog(6);
    check("recover_nosig", int'(no_signal), 0);
    check("recover_noresult", int'(period_valid), 0);
    tog(6);
    check("recover_period", int'(period), 6);

    // Reset with cnt at 3, tone low so the synchronizer is quiet.
    if (tone_in == 1'b0) tog(8);
    tone_in = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("midreset");
    reset_n = 1'b1;
    tog(4);
    check("arm_noresult", int'(period_valid), 0);
    check("arm_period", int'(period), 0);
    repeat (3) tog(4);
    check("post_reset_period", int'(period), 4);

    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
